// File: rtl/bram_stream_pkg.sv
// Shared defaults, FIFO depth and FSM state type for the BRAM stream reader.
package bram_stream_pkg;

   localparam int unsigned AddrWDefault = 8;
   localparam int unsigned DataWDefault = 16;
   localparam int unsigned FifoDepth    = 3;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   // Modulo-3 pointer advance for the 3-entry FIFO.
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(FifoDepth - 1)) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready stream carrying BRAM words out of the reader.
interface bram_stream_reader_if
   import bram_stream_pkg::*;
#(
   parameter int unsigned DATA_W = DataWDefault
);
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;

   modport master (output m_data, output m_valid, output m_last, input m_ready);
   modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/bram_rd_fifo3.sv
// 3-entry first-word-fall-through FIFO holding BRAM words plus a last-beat tag.
module bram_rd_fifo3
   import bram_stream_pkg::*;
#(
   parameter int unsigned DATA_W = DataWDefault
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              push_last_i,
   input  logic              pop_i,
   output logic [1:0]        occ_o,
   output logic              empty_o,
   output logic [DATA_W-1:0] head_data_o,
   output logic              head_last_o
);

   logic [DATA_W-1:0]    data_q [FifoDepth];
   logic [FifoDepth-1:0] last_q;
   logic [1:0]           wr_ptr_q, rd_ptr_q, occ_q;
   logic                 do_pop;

   assign empty_o     = (occ_q == 2'd0);
   assign do_pop      = pop_i && !empty_o;
   assign occ_o       = occ_q;
   assign head_data_o = data_q[rd_ptr_q];
   assign head_last_o = last_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FifoDepth; i++) data_q[i] <= '0;
         last_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push_i) begin
            data_q[wr_ptr_q] <= push_data_i;
            last_q[wr_ptr_q] <= push_last_i;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         occ_q <= occ_q + {1'b0, push_i} - {1'b0, do_pop};
      end
   end

   // The issue throttle upstream guarantees a free slot for every read in flight.
   push_full_a: assert property (@(posedge clk) disable iff (rst) !(push_i && occ_q == 2'd3));

endmodule

// File: rtl/bram_stream_reader.sv
// Streams an address window out of a 1-cycle-latency BRAM onto a valid/ready stream.
// Optional BRAM_STREAM_READER_CSUM_EN adds a modular sum of all accepted beats.
module bram_stream_reader
   import bram_stream_pkg::*;
#(
   parameter int unsigned ADDR_W = AddrWDefault,
   parameter int unsigned DATA_W = DataWDefault
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W:0]      length,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W-1:0]    raddr,
   input  logic [DATA_W-1:0]    rdata,
   bram_stream_reader_if.master m_axis
`ifdef BRAM_STREAM_READER_CSUM_EN
   ,
   output logic [DATA_W-1:0]    csum
`endif
);

   localparam logic [ADDR_W:0] CntOne = (ADDR_W + 1)'(1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   raddr_q, raddr_d;
   logic [ADDR_W:0]     issue_cnt_q, issue_cnt_d, beat_cnt_q, beat_cnt_d;
   logic                inflight_q, inflight_d, inflight_last_q, inflight_last_d;
   logic                issue, pop, fifo_empty, head_last;
   logic [1:0]          fifo_occ;
   logic [DATA_W-1:0]   head_data;

   assign pop   = !fifo_empty && m_axis.m_ready;
   // Count the read in flight so every issued word is sure of a FIFO slot.
   assign issue = (state_q == StRun) && (issue_cnt_q != '0) &&
                  (({1'b0, fifo_occ} + {2'b00, inflight_q}) < 3'd3);

   always_comb begin
      state_d         = state_q;
      raddr_d         = raddr_q;
      issue_cnt_d     = issue_cnt_q;
      beat_cnt_d      = beat_cnt_q;
      inflight_d      = issue;
      inflight_last_d = issue && (issue_cnt_q == CntOne);
      if (issue) begin
         raddr_d     = raddr_q + ADDR_W'(1);
         issue_cnt_d = issue_cnt_q - CntOne;
      end
      if (pop) beat_cnt_d = beat_cnt_q - CntOne;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (length == '0) begin
                  state_d = StDone;
               end else begin
                  state_d     = StRun;
                  raddr_d     = base_addr;
                  issue_cnt_d = length;
                  beat_cnt_d  = length;
               end
            end
         end
         StRun:   if (issue_cnt_d == '0) state_d = StDrain;
         StDrain: if (pop && beat_cnt_q == CntOne) state_d = StDone;
         StDone:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         raddr_q         <= '0;
         issue_cnt_q     <= '0;
         beat_cnt_q      <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         raddr_q         <= raddr_d;
         issue_cnt_q     <= issue_cnt_d;
         beat_cnt_q      <= beat_cnt_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
      end
   end

   bram_rd_fifo3 #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_data_i (rdata),
      .push_last_i (inflight_last_q),
      .pop_i       (pop),
      .occ_o       (fifo_occ),
      .empty_o     (fifo_empty),
      .head_data_o (head_data),
      .head_last_o (head_last)
   );

   assign busy           = (state_q == StRun) || (state_q == StDrain);
   assign done           = (state_q == StDone);
   assign raddr          = raddr_q;
   assign m_axis.m_valid = !fifo_empty;
   assign m_axis.m_data  = head_data;
   assign m_axis.m_last  = !fifo_empty && head_last;

`ifdef BRAM_STREAM_READER_CSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (state_q == StIdle && start) csum_d = '0;
      else if (pop)                   csum_d = csum_q + head_data;
   end

   always_ff @(posedge clk) begin
      if (rst) csum_q <= '0;
      else     csum_q <= csum_d;
   end

   assign csum = csum_q;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: directed windows, stalls, wrap, abort and zero length.
`timescale 1ns/1ps
module tb_bram_stream_reader;
   import bram_stream_pkg::*;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 16;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic          busy, done;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata;
   logic [DW-1:0] mem [256];
`ifdef BRAM_STREAM_READER_CSUM_EN
   logic [DW-1:0] csum;
`endif

   beat_t sb[$];
   int    checks = 0;
   int    errors = 0;
   logic  toggle_mode = 1'b0;
   logic  zlen_expect = 1'b0;
   int    cyc = 0;

   bram_stream_reader_if #(.DATA_W(DW)) s_if ();

   bram_stream_reader #(
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .raddr     (raddr),
      .rdata     (rdata),
      .m_axis    (s_if)
`ifdef BRAM_STREAM_READER_CSUM_EN
      ,
      .csum      (csum)
`endif
   );

   always #5 clk = ~clk;

   // Registered-read BRAM model.
   always @(posedge clk) rdata <= mem[raddr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Downstream ready: constant 1, or the repeating 1,0,0,1 pattern.
   initial begin
      s_if.m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (toggle_mode) s_if.m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         else             s_if.m_ready = 1'b1;
      end
   end

   // Monitor: pops the scoreboard on every handshake, checks done timing and stall stability.
   initial begin
      beat_t         exp;
      logic          hs_last_prev = 1'b0;
      logic          stall_prev = 1'b0;
      logic [DW-1:0] stall_data = '0;
      logic          stall_last = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hs_last_prev = 1'b0;
            stall_prev   = 1'b0;
         end else begin
            chk("done_timing", done, hs_last_prev || zlen_expect);
            if (stall_prev) begin
               chk("stall_valid", s_if.m_valid, 1'b1);
               chk("stall_data", s_if.m_data, stall_data);
               chk("stall_last", s_if.m_last, stall_last);
            end
            hs_last_prev = 1'b0;
            if (s_if.m_valid && s_if.m_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_beat", s_if.m_data, 32'hDEAD_BEEF);
               end else begin
                  exp = sb.pop_front();
                  chk("beat_data", s_if.m_data, exp.data);
                  chk("beat_last", s_if.m_last, exp.last);
                  hs_last_prev = exp.last;
               end
            end
            stall_prev = s_if.m_valid && !s_if.m_ready;
            stall_data = s_if.m_data;
            stall_last = s_if.m_last;
         end
      end
   end

   // Drives a one-cycle start and queues the expected beats; returns just after cycle 1 begins.
   task automatic start_pulse(input logic [AW-1:0] b, input int n);
      logic [AW-1:0] a;
      beat_t         e;
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = b;
      length    = (AW + 1)'(n);
      for (int i = 0; i < n; i++) begin
         a      = b + AW'(i);
         e.data = mem[a];
         e.last = (i == n - 1);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (n < budget) begin
         @(negedge clk);
         if (done) break;
         n++;
      end
      if (n >= budget) chk("done_timeout", 32'd0, 32'd1);
      chk("sb_drained", sb.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_raddr"}, raddr, 8'h00);
      chk({tag, "_valid"}, s_if.m_valid, 1'b0);
      chk({tag, "_last"}, s_if.m_last, 1'b0);
      chk({tag, "_data"}, s_if.m_data, 16'h0000);
   endtask

   initial begin
      #100_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("reset");

      // Window at 0x10: latency 3, back-to-back beats 0x30..0x39.
      start_pulse(8'h10, 4);
      @(negedge clk);
      chk("t1_busy_c1", busy, 1'b1);
      chk("t1_raddr_c1", raddr, 8'h10);
      chk("t1_valid_c1", s_if.m_valid, 1'b0);
      @(negedge clk);
      chk("t1_valid_c2", s_if.m_valid, 1'b0);
      @(negedge clk);
      chk("t1_valid_c3", s_if.m_valid, 1'b1);
      chk("t1_data_c3", s_if.m_data, 16'h0030);
      wait_done(50);
      chk("t1_busy_at_done", busy, 1'b0);

      // Address wrap 0xFE -> 0x01.
      start_pulse(8'hFE, 4);
      @(negedge clk); chk("t2_raddr_c1", raddr, 8'hFE);
      @(negedge clk); chk("t2_raddr_c2", raddr, 8'hFF);
      @(negedge clk); chk("t2_raddr_c3", raddr, 8'h00);
      @(negedge clk); chk("t2_raddr_c4", raddr, 8'h01);
      wait_done(50);

      // Backpressure with ready 1,0,0,1,...
      toggle_mode = 1'b1;
      start_pulse(8'h20, 6);
      wait_done(200);
      toggle_mode = 1'b0;

      // Zero length: done in cycle 1, no beats, never busy.
      start_pulse(8'h30, 0);
      zlen_expect = 1'b1;
      @(negedge clk);
      chk("t4_done_c1", done, 1'b1);
      chk("t4_busy_c1", busy, 1'b0);
      chk("t4_valid_c1", s_if.m_valid, 1'b0);
      @(posedge clk);
      #1;
      zlen_expect = 1'b0;
      @(negedge clk);
      chk("t4_valid_c2", s_if.m_valid, 1'b0);

      // A start while busy is ignored.
      start_pulse(8'h40, 3);
      start     = 1'b1;
      base_addr = 8'h80;
      length    = 9'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(50);
      repeat (4) @(negedge clk);
      chk("t5_idle_busy", busy, 1'b0);
      chk("t5_idle_valid", s_if.m_valid, 1'b0);

      // Reset in cycle 5 of a 20-word transfer aborts it silently.
      start_pulse(8'h50, 20);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      chk_reset_outputs("abort");
      repeat (4) @(negedge clk);
      start_pulse(8'h60, 5);
      wait_done(50);

      // Full memory, wrapping back to the base.
      start_pulse(8'h80, 256);
      wait_done(400);

`ifdef BRAM_STREAM_READER_CSUM_EN
      mem[8'hA0] = 16'hFFFF;
      mem[8'hA1] = 16'h0002;
      start_pulse(8'hA0, 2);
      wait_done(50);
      chk("csum_at_done", csum, 16'h0001);
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side initiator for the 256x16 iCE40 block-RAM wrapper: drives the wrapper's read address and consumes its registered read data.
- Streams a programmed address window out on a valid/ready stream interface.
- Hides the 1-cycle BRAM read latency and absorbs downstream backpressure without losing words.
- Sits between BRAM-held buffers (text/frame/sample RAM) and any stream consumer (video shifter, UART TX, DMA).

Parameters:
- ADDR_W, 8, BRAM word address width; depth = 2**ADDR_W.
- DATA_W, 16, BRAM word width.

Ports:
- clk  in  1  single clock; the BRAM read clock is driven from the same clk.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle request; ignored while busy.
- base_addr  in  ADDR_W  first address, sampled on start.
- length  in  ADDR_W+1  number of words, 0..256, sampled on start.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  1-cycle pulse after the last beat is accepted.
- raddr  out  ADDR_W  to the BRAM read address.
- rdata  in  DATA_W  from BRAM; valid the cycle after raddr is sampled.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high with the final beat.

Behaviour:
- Reset: busy=0, done=0, raddr=0, m_valid=0, m_last=0, m_data=0. FIFO is emptied, counters are cleared, state=IDLE.
- A reset mid-transfer aborts the transfer. No done pulse. BRAM contents are untouched.
- Clock and reset are fixed: one clock (clk); reset (rst) is synchronous and active-high.
- States:
  - IDLE: start=1 with length>0 -> RUN. Load raddr<=base_addr, issue_cnt<=length, beat_cnt<=length. start=1 with length=0 -> DONE, with no beats.
  - RUN: issue reads. When issue_cnt reaches 0 -> DRAIN.
  - DRAIN: wait until the final beat is accepted -> DONE.
  - DONE: done=1 for one cycle -> IDLE. busy=0 in DONE.
- Issue rule:
  - A read issues in a cycle iff state=RUN, issue_cnt>0, and fifo_occ + inflight < 3.
  - On issue: raddr increments mod 2**ADDR_W (255 wraps to 0), issue_cnt decrements, and inflight is set for the next cycle.
  - When inflight=1, rdata is pushed into the FIFO at the end of that cycle.
- Internal FIFO:
  - Depth 3, first-word-fall-through.
  - m_valid = FIFO not empty; m_data = FIFO head.
  - Pop on m_valid & m_ready.
- m_last=1 while m_valid=1 and beat_cnt==1.
- Handshake rules:
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
- Latency: start in cycle 0 -> raddr=base in cycle 1 (issue) -> rdata in cycle 2 -> m_valid in cycle 3.
- Throughput: one beat per cycle while m_ready=1.
- Overflow is impossible by construction; a FIFO push when full is an assertion failure.
- start while busy is ignored, with no effect on counters.
- length=256 streams the full memory, wrapping back to base_addr.

Optional Feature:
- Macro: BRAM_STREAM_READER_CSUM_EN.
- Enabled: adds an output port csum [DATA_W] holding the 16-bit modular sum of all accepted beats. It is cleared on an accepted start and is valid when done=1. It holds until the next start. Reset value is 0.
- Disabled: the port and adder are absent; all other behaviour is identical.

Decomposition:
- Package bram_stream_pkg:
  - ADDR_W/DATA_W defaults.
  - FIFO depth constant (3).
  - State enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module bram_rd_fifo3: 3-entry FWFT FIFO with push, pop, occ[1:0], head data and last flag.

Test Plan:
- base=0x10, len=4, BRAM[i]=i*3, m_ready=1 -> beats 0x30,0x33,0x36,0x39. First m_valid in cycle 3, consecutive beats, m_last on 0x39, done pulse on the cycle after the last handshake.
- base=0xFE, len=4 -> raddr sequence FE,FF,00,01 and data in that order.
- len=6 with m_ready toggling 1,0,0,1,... -> all 6 words in order, no duplicates or drops. FIFO occ never exceeds 3. m_data stable while stalled.
- len=0 -> done one cycle after start, m_valid stays 0. Second start during busy -> ignored, exactly len beats.
- rst asserted in cycle 5 of a len=20 transfer -> next cycle all outputs at reset values, no done. A fresh start completes normally.
- BRAM_STREAM_READER_CSUM_EN defined, data 0xFFFF,0x0002 -> csum=0x0001 at done.
